// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the dmem MMIO window: register offsets, STATUS bits
// and FIFOSTAT field layout.
package dmem_mmio_responder_pkg;

  localparam logic [3:0] OFF_CYCLES   = 4'h0;
  localparam logic [3:0] OFF_CMP      = 4'h1;
  localparam logic [3:0] OFF_STATUS   = 4'h2;
  localparam logic [3:0] OFF_TXDATA   = 4'h3;
  localparam logic [3:0] OFF_FIFOSTAT = 4'h4;
  localparam logic [3:0] OFF_SCRATCH  = 4'h5;

  localparam int STAT_TIMER = 0;
  localparam int STAT_OVF   = 1;

  localparam int FSTAT_COUNT_W = 4;
  localparam int FSTAT_FULL    = 8;
  localparam int FSTAT_EMPTY   = 9;

  function automatic logic [31:0] fifostat_word(input logic [FSTAT_COUNT_W-1:0] count,
                                                input logic full,
                                                input logic empty);
    logic [31:0] w;
    w = '0;
    w[FSTAT_COUNT_W-1:0] = count;
    w[FSTAT_FULL]        = full;
    w[FSTAT_EMPTY]       = empty;
    return w;
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_fifo.sv
// Synchronous FIFO for the MMIO transmit path. A push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module mmio_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = wdata;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared too so the head word is never X after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: claims a 16-word MMIO window, gates dmem writes
// to it and muxes window read data back with the syncram's 1-cycle latency.
module dmem_mmio_responder
  import dmem_mmio_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 12'hFF0,
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  input  logic [DATA_WIDTH-1:0] q_dmem_in,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  dmem_wren,
  output logic                  sel,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  timer_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] cycles_q, cycles_d;
  logic [DATA_WIDTH-1:0] cmp_q, cmp_d;
  logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
  logic [1:0]            status_q, status_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  sel_q, sel_d;

  logic [3:0]    offset;
  logic          win_wr, w1c, push_req, pop, overflow, timer_match;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign sel         = (address[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign offset      = address[3:0];
  assign win_wr      = wren & sel;
  assign dmem_wren   = wren & ~sel;
  assign w1c         = win_wr & (offset == OFF_STATUS);
  assign push_req    = win_wr & (offset == OFF_TXDATA);
  assign tx_valid    = ~fifo_empty;
  assign pop         = tx_valid & tx_ready;
  assign overflow    = push_req & fifo_full & ~pop;
  assign timer_match = (cycles_q == cmp_q) && (cmp_q != '0);
  assign timer_irq   = status_q[STAT_TIMER];
  assign q           = sel_q ? rd_q : q_dmem_in;

  mmio_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .wdata (data),
    .rdata (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    cycles_d  = cycles_q + DATA_WIDTH'(1);
    cmp_d     = (win_wr && offset == OFF_CMP) ? data : cmp_q;
    scratch_d = (win_wr && offset == OFF_SCRATCH) ? data : scratch_q;
    // A new match outranks a clear landing in the same cycle.
    status_d[STAT_TIMER] = timer_match |
                           (status_q[STAT_TIMER] & ~(w1c & data[STAT_TIMER]));
    status_d[STAT_OVF]   = overflow |
                           (status_q[STAT_OVF] & ~(w1c & data[STAT_OVF]));
    sel_d = sel;
    case (offset)
      OFF_CYCLES:   rd_d = cycles_q;
      OFF_CMP:      rd_d = cmp_q;
      OFF_STATUS:   rd_d = DATA_WIDTH'(status_q);
      OFF_FIFOSTAT: rd_d = DATA_WIDTH'(fifostat_word(FSTAT_COUNT_W'(fifo_count),
                                                     fifo_full, fifo_empty));
      OFF_SCRATCH:  rd_d = scratch_q;
      default:      rd_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycles_q  <= '0;
      cmp_q     <= '0;
      scratch_q <= '0;
      status_q  <= '0;
      rd_q      <= '0;
      sel_q     <= 1'b0;
    end else begin
      cycles_q  <= cycles_d;
      cmp_q     <= cmp_d;
      scratch_q <= scratch_d;
      status_q  <= status_d;
      rd_q      <= rd_d;
      sel_q     <= sel_d;
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based model of the register window.
module tb_dmem_mmio_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] address;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem_in;
  logic [31:0] q;
  logic        dmem_wren;
  logic        sel;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  always #5 clock = ~clock;

  dmem_mmio_responder dut (
    .clock     (clock),
    .reset     (reset),
    .address   (address),
    .data      (data),
    .wren      (wren),
    .q_dmem_in (q_dmem_in),
    .q         (q),
    .dmem_wren (dmem_wren),
    .sel       (sel),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .timer_irq (timer_irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the window, advanced once per clock.
  logic [31:0] m_cyc, m_cmp, m_scratch, m_prd;
  logic [1:0]  m_st;
  logic        m_psel;
  logic [31:0] m_fifo[$];

  logic [31:0] last_q, last_txd;
  logic        last_wren, last_irq, last_valid;

  localparam logic [11:0] IDLE = 12'h010;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_cmp = 0; m_scratch = 0; m_st = 0;
    m_psel = 0; m_prd = 0;
    m_fifo.delete();
  endtask

  task automatic step(input logic [11:0] a, input logic [31:0] d, input logic w,
                      input logic rdy, input logic rst);
    logic        s, pop_m, push_m, w1c_m, match_m;
    logic [3:0]  off;
    logic [31:0] rdv;
    int          sz;
    @(negedge clock);
    address = a; data = d; wren = w; tx_ready = rdy; reset = rst;
    q_dmem_in = $urandom();
    #1;
    s   = (a[11:4] == 8'hFF);
    off = a[3:0];
    sz  = m_fifo.size();
    chk("sel", sel, s);
    chk("dmem_wren", dmem_wren, w & ~s);
    chk("q", q, m_psel ? m_prd : q_dmem_in);
    chk("tx_valid", tx_valid, sz > 0);
    if (sz > 0) chk("tx_data", tx_data, m_fifo[0]);
    chk("timer_irq", timer_irq, m_st[0]);
    last_q = q; last_wren = dmem_wren; last_irq = timer_irq;
    last_valid = tx_valid; last_txd = tx_data;

    case (off)
      4'h0: rdv = m_cyc;
      4'h1: rdv = m_cmp;
      4'h2: rdv = {30'b0, m_st};
      4'h4: rdv = 32'(sz) | (sz == 8 ? 32'h100 : 32'h0) | (sz == 0 ? 32'h200 : 32'h0);
      4'h5: rdv = m_scratch;
      default: rdv = 32'h0;
    endcase

    if (rst) begin
      model_reset();
    end else begin
      pop_m   = (sz > 0) && rdy;
      push_m  = w && s && off == 4'h3;
      w1c_m   = w && s && off == 4'h2;
      match_m = (m_cyc == m_cmp) && (m_cmp != 0);
      m_st[0] = match_m || (m_st[0] && !(w1c_m && d[0]));
      m_st[1] = (push_m && sz == 8 && !pop_m) || (m_st[1] && !(w1c_m && d[1]));
      if (pop_m) void'(m_fifo.pop_front());
      if (push_m && (sz < 8 || pop_m)) m_fifo.push_back(d);
      if (w && s && off == 4'h1) m_cmp = d;
      if (w && s && off == 4'h5) m_scratch = d;
      m_cyc  = m_cyc + 1;
      m_psel = s;
      m_prd  = rdv;
    end
    @(posedge clock);
  endtask

  initial begin
    logic [31:0] v, first_w;
    int pct;
    reset = 1; address = IDLE; data = 0; wren = 0; tx_ready = 0; q_dmem_in = 0;
    repeat (3) @(posedge clock);
    model_reset();

    // Counter read latency and pass-through
    for (int i = 0; i < 10; i++) step(IDLE, 0, 0, 0, 0);
    step(12'hFF0, 0, 0, 0, 0);
    step(IDLE, 0, 0, 0, 0);
    chk("cycles_at_10", last_q, 32'd10);

    // Scratch and write gating
    step(12'hFF5, 32'hDEADBEEF, 1, 0, 0);
    chk("win_write_gated", last_wren, 1'b0);
    step(12'hFF5, 0, 0, 0, 0);
    step(12'h020, 32'h1234, 1, 0, 0);
    chk("scratch_rd", last_q, 32'hDEADBEEF);
    chk("dmem_write", last_wren, 1'b1);

    // Timer match, hold, clear, clear colliding with a match
    step(12'hFF1, 32'd50, 1, 0, 0);
    for (int i = 0; i < 100 && m_cyc != 50; i++) step(IDLE, 0, 0, 0, 0);
    step(IDLE, 0, 0, 0, 0);
    chk("irq_before_match", last_irq, 1'b0);
    step(IDLE, 0, 0, 0, 0);
    chk("irq_rise", last_irq, 1'b1);
    step(IDLE, 0, 0, 0, 0);
    chk("irq_hold", last_irq, 1'b1);
    step(12'hFF2, 32'd1, 1, 0, 0);
    step(IDLE, 0, 0, 0, 0);
    chk("irq_cleared", last_irq, 1'b0);
    v = m_cyc + 5;
    step(12'hFF1, v, 1, 0, 0);
    for (int i = 0; i < 20 && m_cyc != v; i++) step(IDLE, 0, 0, 0, 0);
    step(12'hFF2, 32'd1, 1, 0, 0);
    step(IDLE, 0, 0, 0, 0);
    chk("set_beats_clear", last_irq, 1'b1);
    step(12'hFF2, 32'd1, 1, 0, 0);

    // Fill past full, check FIFOSTAT/STATUS and head
    for (int i = 1; i <= 9; i++) step(12'hFF3, 32'(i), 1, 0, 0);
    step(12'hFF4, 0, 0, 0, 0);
    step(12'hFF2, 0, 0, 0, 0);
    chk("fifostat_full", last_q, 32'h108);
    chk("head_word", last_txd, 32'd1);
    step(IDLE, 0, 0, 0, 0);
    chk("status_ovf", last_q, 32'h2);
    step(12'hFF2, 32'h2, 1, 0, 0);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      step(IDLE, 0, 0, 1, 0);
      chk("drain_order", last_txd, 32'(i));
    end
    step(12'hFF4, 0, 0, 1, 0);
    chk("drained_invalid", last_valid, 1'b0);
    step(IDLE, 0, 0, 0, 0);
    chk("fifostat_empty", last_q, 32'h200);

    // Push into full FIFO while popping
    for (int i = 0; i < 8; i++) step(12'hFF3, 32'h10 + 32'(i), 1, 0, 0);
    step(12'hFF3, 32'hAA, 1, 1, 0);
    step(12'hFF4, 0, 0, 0, 0);
    step(12'hFF2, 0, 0, 0, 0);
    chk("full_push_pop_cnt", last_q, 32'h108);
    step(IDLE, 0, 0, 0, 0);
    chk("full_push_pop_no_ovf", last_q, 32'h0);
    first_w = 0;
    for (int i = 0; i < 8; i++) begin
      step(IDLE, 0, 0, 1, 0);
      if (i == 0) first_w = last_txd;
    end
    chk("first_after_pop", first_w, 32'h11);
    chk("aa_last_out", last_txd, 32'hAA);

    // Reset in the middle of a drain
    for (int i = 0; i < 4; i++) step(12'hFF3, 32'h40 + 32'(i), 1, 0, 0);
    step(IDLE, 0, 0, 1, 0);
    step(IDLE, 0, 0, 1, 0);
    step(IDLE, 0, 0, 1, 1);
    step(12'hFF4, 0, 0, 1, 0);
    chk("reset_valid", last_valid, 1'b0);
    step(IDLE, 0, 0, 0, 0);
    chk("reset_count", last_q, 32'h200);

    // Random traffic against the model
    pct = 50;
    for (int n = 0; n < 3000; n++) begin
      logic [11:0] a;
      logic [31:0] d;
      if (n % 300 == 0) pct = $urandom_range(0, 100);
      a = ($urandom_range(0, 9) < 7) ? {8'hFF, 4'($urandom_range(0, 7))} : 12'($urandom());
      d = $urandom();
      if (a[3:0] == 4'h1 && $urandom_range(0, 1) == 1) d = m_cyc + $urandom_range(1, 12);
      step(a, d, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < pct,
           $urandom_range(0, 499) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
